// File: rtl/lsu.sv
// Load/store unit: drives a req/gnt/rvalid data bus, stalls the core, steers store lanes and extends loads.
// Optional LSU_MISALIGN_TRAP_EN: misaligned HALF/WORD accesses skip the bus and raise misalign in DONE.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  localparam logic [2:0] RD_NONE   = 3'd0;
  localparam logic [2:0] RD_BYTE   = 3'd1;
  localparam logic [2:0] RD_HALF   = 3'd2;
  localparam logic [2:0] RD_WORD   = 3'd3;
  localparam logic [2:0] RD_BYTE_U = 3'd4;
  localparam logic [2:0] RD_HALF_U = 3'd5;

  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_BYTE = 2'd1;
  localparam logic [1:0] WR_HALF = 2'd2;
  localparam logic [1:0] WR_WORD = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state_r;
  logic [2:0]  op_r;
  logic [1:0]  lo_r;
  logic        op_present_s;
  logic        is_store_s;
  logic [1:0]  size_s;
  logic        misalign_s;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: store_be = 4'b0001 << lo;
      SZ_HALF: store_be = lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (op)
      RD_BYTE:   load_ext = {{24{b[7]}}, b};
      RD_HALF:   load_ext = {{16{h[15]}}, h};
      RD_BYTE_U: load_ext = {24'h000000, b};
      RD_HALF_U: load_ext = {16'h0000, h};
      RD_WORD:   load_ext = word;
      default:   load_ext = word;
    endcase
  endfunction

  assign is_store_s   = (mem_write != WR_NONE);
  assign op_present_s = is_store_s || (mem_read != RD_NONE);

  // Access size of the incoming op; a store takes precedence over a load.
  always_comb begin
    size_s = SZ_WORD;
    if (is_store_s) begin
      case (mem_write)
        WR_BYTE: size_s = SZ_BYTE;
        WR_HALF: size_s = SZ_HALF;
        WR_WORD: size_s = SZ_WORD;
        default: size_s = SZ_WORD;
      endcase
    end else begin
      case (mem_read)
        RD_BYTE, RD_BYTE_U: size_s = SZ_BYTE;
        RD_HALF, RD_HALF_U: size_s = SZ_HALF;
        default:            size_s = SZ_WORD;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = ((size_s == SZ_HALF) && addr[0]) ||
                      ((size_s == SZ_WORD) && (addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign stall = ((state_r == S_IDLE) && op_present_s) ||
                 (state_r == S_REQ) || (state_r == S_WAIT);

  // Transaction FSM; bus outputs are loaded only on the IDLE->REQ transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      op_r       <= RD_NONE;
      lo_r       <= 2'b00;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0000_0000;
      dbus_be    <= 4'b0000;
      dbus_wdata <= 32'h0000_0000;
      rdata      <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (op_present_s && misalign_s) begin
            rdata   <= 32'h0000_0000;
            state_r <= S_DONE;
          end else if (op_present_s) begin
            op_r       <= mem_read;
            lo_r       <= addr[1:0];
            dbus_req   <= 1'b1;
            dbus_we    <= is_store_s;
            dbus_addr  <= {addr[31:2], 2'b00};
            dbus_be    <= is_store_s ? store_be(size_s, addr[1:0]) : 4'b1111;
            dbus_wdata <= store_data(size_s, wdata);
            state_r    <= S_REQ;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_REQ: begin
          if (dbus_gnt) begin
            dbus_req <= 1'b0;
            state_r  <= S_WAIT;
          end else begin
            state_r <= S_REQ;
          end
        end
        S_WAIT: begin
          if (dbus_rvalid) begin
            if (!dbus_we) begin
              rdata <= load_ext(op_r, lo_r, dbus_rdata);
            end else begin
              rdata <= rdata;
            end
            state_r <= S_DONE;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Flag is set only on the IDLE->DONE trap path, so it is high for that single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign <= 1'b0;
    end else begin
      misalign <= (state_r == S_IDLE) && op_present_s && misalign_s;
    end
  end
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table driven through a bus responder with programmable grant
// delay, plus hand-written reset and mid-transaction reset sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_vec = 0;
  int n_err = 0;

  lsu dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] bus_rd;
    int          gdly;
    int          exp_stall;
    bit          exp_req;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    bit          chk_wd;
    logic [31:0] exp_rdata;
    bit          exp_mis;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] bus_rd, input int gdly,
                              input int exp_stall, input bit exp_req, input logic exp_we,
                              input logic [3:0] exp_be, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wd, input bit chk_wd,
                              input logic [31:0] exp_rdata, input bit exp_mis);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.bus_rd = bus_rd; v.gdly = gdly;
    v.exp_stall = exp_stall; v.exp_req = exp_req; v.exp_we = exp_we; v.exp_be = exp_be;
    v.exp_addr = exp_addr; v.exp_wd = exp_wd; v.chk_wd = chk_wd;
    v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          cnt;
    int          wait_n;
    bit          granted;
    bit          rv_sent;
    bit          saw_req;
    bit          done;
    logic        s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr;
    logic [31:0] s_wd;
    cnt = 0; wait_n = 0; granted = 0; rv_sent = 0; saw_req = 0; done = 0;
    s_we = 1'b0; s_be = 4'b0000; s_addr = 32'h0; s_wd = 32'h0;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; addr = v.a; wdata = v.wd;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dbus_gnt = 1'b0;
        dbus_rvalid = 1'b0;
      end
      #1;
      if (stall) begin
        cnt++;
        if (granted && !rv_sent) begin
          dbus_rvalid = 1'b1;
          dbus_rdata = v.bus_rd;
          rv_sent = 1;
        end
        if (dbus_req && !granted) begin
          if (!saw_req) begin
            s_we = dbus_we; s_be = dbus_be; s_addr = dbus_addr; s_wd = dbus_wdata;
            saw_req = 1;
          end else begin
            chk($sformatf("v%0d hold_ctl", idx), {27'h0, dbus_we, dbus_be}, {27'h0, s_we, s_be});
            chk($sformatf("v%0d hold_addr", idx), dbus_addr, s_addr);
            chk($sformatf("v%0d hold_wdata", idx), dbus_wdata, s_wd);
          end
          if (wait_n == v.gdly) begin
            dbus_gnt = 1'b1;
            granted = 1;
          end else begin
            wait_n++;
          end
        end
      end else begin
        done = 1;
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
`ifdef LSU_MISALIGN_TRAP_EN
        chk($sformatf("v%0d misalign", idx), {31'h0, misalign}, {31'h0, v.exp_mis});
`endif
      end
    end
    if (!done) chk($sformatf("v%0d timeout", idx), 32'h0, 32'h1);
    chk($sformatf("v%0d stall_cycles", idx), cnt, v.exp_stall);
    chk($sformatf("v%0d bus_req_seen", idx), {31'h0, saw_req}, {31'h0, v.exp_req});
    if (saw_req) begin
      chk($sformatf("v%0d we", idx), {31'h0, s_we}, {31'h0, v.exp_we});
      chk($sformatf("v%0d be", idx), {28'h0, s_be}, {28'h0, v.exp_be});
      chk($sformatf("v%0d addr", idx), s_addr, v.exp_addr);
      if (v.chk_wd) chk($sformatf("v%0d wdata", idx), s_wd, v.exp_wd);
    end
    @(negedge clk);
    mem_read = 3'd0; mem_write = 2'd0;
    #1;
    chk($sformatf("v%0d idle_stall", idx), {31'h0, stall}, 32'h0);
    chk($sformatf("v%0d idle_req", idx), {31'h0, dbus_req}, 32'h0);
  endtask

  initial begin
    // rd: 0 NONE 1 BYTE 2 HALF 3 WORD 4 BYTE_U 5 HALF_U ; wr: 0 NONE 1 BYTE 2 HALF 3 WORD
    tbl[0] = mk(3'd1, 2'd0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 3, 1, 1'b0, 4'b1111,
                32'h0000_1000, 32'h0, 0, 32'hFFFF_FF80, 0);
    tbl[1] = mk(3'd5, 2'd0, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 3, 1, 1'b0, 4'b1111,
                32'h0000_2000, 32'h0, 0, 32'h0000_BEEF, 0);
    tbl[2] = mk(3'd0, 2'd1, 32'h0000_3001, 32'h1122_33AB, 32'hFFFF_FFFF, 0, 3, 1, 1'b1, 4'b0010,
                32'h0000_3000, 32'hABAB_ABAB, 1, 32'h0000_BEEF, 0);
    tbl[3] = mk(3'd0, 2'd3, 32'h0000_5000, 32'hCAFE_F00D, 32'hFFFF_FFFF, 4, 7, 1, 1'b1, 4'b1111,
                32'h0000_5000, 32'hCAFE_F00D, 1, 32'h0000_BEEF, 0);
    tbl[4] = mk(3'd2, 2'd0, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 0, 3, 1, 1'b0, 4'b1111,
                32'h0000_6000, 32'h0, 0, 32'hFFFF_8001, 0);
    tbl[5] = mk(3'd4, 2'd0, 32'h0000_7002, 32'h0, 32'h12C3_4567, 0, 3, 1, 1'b0, 4'b1111,
                32'h0000_7000, 32'h0, 0, 32'h0000_00C3, 0);
    tbl[6] = mk(3'd3, 2'd0, 32'h0000_8000, 32'h0, 32'hDEAD_BEEF, 1, 4, 1, 1'b0, 4'b1111,
                32'h0000_8000, 32'h0, 0, 32'hDEAD_BEEF, 0);
    tbl[7] = mk(3'd0, 2'd2, 32'h0000_9002, 32'hAAAA_5678, 32'h0, 0, 3, 1, 1'b1, 4'b1100,
                32'h0000_9000, 32'h5678_5678, 1, 32'hDEAD_BEEF, 0);
    tbl[8] = mk(3'd3, 2'd1, 32'h0000_A000, 32'h0000_007E, 32'h1111_1111, 0, 3, 1, 1'b1, 4'b0001,
                32'h0000_A000, 32'h7E7E_7E7E, 1, 32'hDEAD_BEEF, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[9]  = mk(3'd3, 2'd0, 32'h0000_4002, 32'h0, 32'h55AA_55AA, 0, 1, 0, 1'b0, 4'b0000,
                 32'h0, 32'h0, 0, 32'h0000_0000, 1);
    tbl[10] = mk(3'd2, 2'd0, 32'h0000_6001, 32'h0, 32'h1234_F00F, 0, 1, 0, 1'b0, 4'b0000,
                 32'h0, 32'h0, 0, 32'h0000_0000, 1);
`else
    tbl[9]  = mk(3'd3, 2'd0, 32'h0000_4002, 32'h0, 32'h55AA_55AA, 0, 3, 1, 1'b0, 4'b1111,
                 32'h0000_4000, 32'h0, 0, 32'h55AA_55AA, 0);
    tbl[10] = mk(3'd2, 2'd0, 32'h0000_6001, 32'h0, 32'h1234_F00F, 0, 3, 1, 1'b0, 4'b1111,
                 32'h0000_6000, 32'h0, 0, 32'hFFFF_F00F, 0);
`endif

    rst = 1'b1; mem_read = 3'd0; mem_write = 2'd0; addr = 32'h0; wdata = 32'h0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset req", {31'h0, dbus_req}, 32'h0);
    chk("reset we_be", {27'h0, dbus_we, dbus_be}, 32'h0);
    chk("reset addr", dbus_addr, 32'h0);
    chk("reset wdata", dbus_wdata, 32'h0);
    chk("reset rdata", rdata, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("reset misalign", {31'h0, misalign}, 32'h0);
`endif

    for (int i = 0; i < 11; i++) run_vec(i, tbl[i]);

    // Reset pulsed while in WAIT; the late response must be ignored.
    @(negedge clk);
    mem_read = 3'd3; addr = 32'h0000_B000;
    @(negedge clk);
    #1;
    chk("rstmid req", {31'h0, dbus_req}, 32'h1);
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    #1;
    chk("rstmid wait_stall", {31'h0, stall}, 32'h1);
    rst = 1'b1; mem_read = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    #1;
    chk("rstmid rdata", rdata, 32'h0);
    chk("rstmid stall", {31'h0, stall}, 32'h0);
    chk("rstmid req_low", {31'h0, dbus_req}, 32'h0);

    // Stray grant and response in IDLE do nothing.
    dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    #1;
    chk("stray rdata", rdata, 32'h0);
    chk("stray stall", {31'h0, stall}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
